// File: rtl/md_unit_pkg.sv
// Shared MDType codes, scheduler state encodings and result bundle for the multiply/divide unit.
// The controller decodes instructions into the same MD_* constants.
package md_unit_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_DIV   = 4'd1;
    localparam logic [3:0] MD_DIVU  = 4'd2;
    localparam logic [3:0] MD_MULT  = 4'd3;
    localparam logic [3:0] MD_MULTU = 4'd4;
    localparam logic [3:0] MD_MFHI  = 4'd5;
    localparam logic [3:0] MD_MFLO  = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;
    localparam logic [3:0] MD_MSUB  = 4'd9;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam int CNT_W = 8;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        keep;
    } md_result_t;

    function automatic logic is_div(input logic [3:0] t);
        return (t == MD_DIV) || (t == MD_DIVU);
    endfunction

    function automatic logic is_multi(input logic [3:0] t);
        return is_div(t) || (t == MD_MULT) || (t == MD_MULTU) || (t == MD_MSUB);
    endfunction

endpackage

// File: rtl/md_calc.sv
// Combinational datapath: product, msub accumulate, quotient/remainder for the multi-cycle ops.
// The result is captured at the start edge and only committed to HI/LO when the busy count expires.
module md_calc
    import md_unit_pkg::*;
(
    input  logic [3:0]  md_type,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output md_result_t  res
);

    logic [63:0] s_prod;
    logic [63:0] u_prod;
    logic [63:0] msub_val;
    logic [31:0] rs_mag;
    logic [31:0] rt_mag;
    logic [31:0] s_divisor;
    logic [31:0] u_divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] s_quot;
    logic [31:0] s_rem;
    logic [31:0] u_quot;
    logic [31:0] u_rem;

    always_comb begin
        s_prod   = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
        u_prod   = {32'd0, rs} * {32'd0, rt};
        msub_val = {hi, lo} - s_prod;

        // Signed divide via magnitudes; 0x80000000 has magnitude 0x80000000 as unsigned,
        // which makes 0x80000000 / -1 fall out as 0x80000000 rem 0 without a special case.
        rs_mag    = rs[31] ? (32'd0 - rs) : rs;
        rt_mag    = rt[31] ? (32'd0 - rt) : rt;
        s_divisor = (rt_mag == 32'd0) ? 32'd1 : rt_mag;
        q_mag     = rs_mag / s_divisor;
        r_mag     = rs_mag % s_divisor;
        s_quot    = (rs[31] ^ rt[31]) ? (32'd0 - q_mag) : q_mag;
        s_rem     = rs[31] ? (32'd0 - r_mag) : r_mag;

        u_divisor = (rt == 32'd0) ? 32'd1 : rt;
        u_quot    = rs / u_divisor;
        u_rem     = rs % u_divisor;

        res = '0;
        case (md_type)
            MD_MULT:  begin res.hi = s_prod[63:32];   res.lo = s_prod[31:0];   end
            MD_MULTU: begin res.hi = u_prod[63:32];   res.lo = u_prod[31:0];   end
            MD_MSUB:  begin res.hi = msub_val[63:32]; res.lo = msub_val[31:0]; end
            MD_DIV:   begin res.hi = s_rem; res.lo = s_quot; res.keep = (rt == 32'd0); end
            MD_DIVU:  begin res.hi = u_rem; res.lo = u_quot; res.keep = (rt == 32'd0); end
            default:  res = '0;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// E-stage multiply/divide unit: owns HI/LO, sequences multi-cycle ops with a busy counter
// and requests a D-stage stall for any muldiv instruction arriving while the unit is occupied.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  e_md_type,
    input  logic        e_valid,
    input  logic [31:0] e_rs,
    input  logic [31:0] e_rt,
    input  logic        d_muldiv,
    output logic        busy,
    output logic        start,
    output logic        stall_req,
    output logic [31:0] md_out,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic             keep;
    logic             acc;
    md_result_t       calc_res;

    md_calc u_calc (
        .md_type (e_md_type),
        .rs      (e_rs),
        .rt      (e_rt),
        .hi      (hi),
        .lo      (lo),
        .res     (calc_res)
    );

    // Anything arriving in E while BUSY is dropped here; the stall rule keeps it from happening.
    assign acc       = e_valid & (state == ST_IDLE);
    assign start     = acc & is_multi(e_md_type);
    assign busy      = (state == ST_BUSY);
    assign stall_req = d_muldiv & (busy | start);

    always_comb begin
        md_out = 32'd0;
        if (e_valid && e_md_type == MD_MFHI) md_out = hi;
        else if (e_valid && e_md_type == MD_MFLO) md_out = lo;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            hi      <= 32'd0;
            lo      <= 32'd0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            keep    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        pend_hi <= calc_res.hi;
                        pend_lo <= calc_res.lo;
                        keep    <= calc_res.keep;
                        cnt     <= is_div(e_md_type) ? DIV_LOAD : MUL_LOAD;
                        state   <= ST_BUSY;
                    end else if (acc && e_md_type == MD_MTHI) begin
                        hi <= e_rs;
                    end else if (acc && e_md_type == MD_MTLO) begin
                        lo <= e_rs;
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        if (!keep) begin
                            hi <= pend_hi;
                            lo <= pend_lo;
                        end
                        keep  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed self-checking bench for md_unit: latency, HI/LO results, stall rule and async reset.
module tb_md_unit;
    import md_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  e_md_type;
    logic        e_valid;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic        d_muldiv;
    logic        busy;
    logic        start;
    logic        stall_req;
    logic [31:0] md_out;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests_run    = 0;
    int tests_failed = 0;

    md_unit #(.MUL_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .e_md_type (e_md_type),
        .e_valid   (e_valid),
        .e_rs      (e_rs),
        .e_rt      (e_rt),
        .d_muldiv  (d_muldiv),
        .busy      (busy),
        .start     (start),
        .stall_req (stall_req),
        .md_out    (md_out),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] t, input logic v, input logic [31:0] a, input logic [31:0] b);
        e_md_type = t;
        e_valid   = v;
        e_rs      = a;
        e_rt      = b;
    endtask

    task automatic idle_e();
        drive(MD_NONE, 1'b0, 32'd0, 32'd0);
    endtask

    // Issue a multi-cycle op, then expect exactly n busy cycles with stall_req tracking d_muldiv.
    task automatic run_multi(input string tag, input logic [3:0] t, input logic [31:0] a,
                             input logic [31:0] b, input int n);
        drive(t, 1'b1, a, b);
        #1;
        check32({tag, " start"}, 32'(start), 32'd1);
        check32({tag, " stall@start"}, 32'(stall_req), 32'(d_muldiv));
        step();
        idle_e();
        for (int i = 0; i < n; i++) begin
            check32($sformatf("%s busy[%0d]", tag, i), 32'(busy), 32'd1);
            check32($sformatf("%s stall[%0d]", tag, i), 32'(stall_req), 32'(d_muldiv));
            step();
        end
        check32({tag, " busy done"}, 32'(busy), 32'd0);
    endtask

    // A muldiv instruction in E while the unit is busy means the stall rule was broken.
    always @(negedge clk) begin
        if (reset === 1'b0 && e_valid && e_md_type >= MD_DIV && e_md_type <= MD_MSUB && busy) begin
            tests_failed++;
            $display("FAIL protocol: muldiv type %0d in E while busy", e_md_type);
        end
    end

    initial begin
        reset    = 1'b1;
        d_muldiv = 1'b1;
        idle_e();
        #12;
        check32("reset busy", 32'(busy), 32'd0);
        check32("reset stall", 32'(stall_req), 32'd0);
        check32("reset hi", hi, 32'd0);
        check32("reset lo", lo, 32'd0);
        check32("reset md_out", md_out, 32'd0);
        reset    = 1'b0;
        d_muldiv = 1'b0;
        step();

        // signed / unsigned multiply
        run_multi("mult", MD_MULT, 32'hFFFF_FFFE, 32'd3, 5);
        check32("mult hi", hi, 32'hFFFF_FFFF);
        check32("mult lo", lo, 32'hFFFF_FFFA);
        run_multi("multu", MD_MULTU, 32'hFFFF_FFFE, 32'd3, 5);
        check32("multu hi", hi, 32'h0000_0002);
        check32("multu lo", lo, 32'hFFFF_FFFA);

        // divides, divide-by-zero, overflow corner
        run_multi("div", MD_DIV, 32'hFFFF_FFF9, 32'd2, 10);
        check32("div hi", hi, 32'hFFFF_FFFF);
        check32("div lo", lo, 32'hFFFF_FFFD);
        run_multi("divu0", MD_DIVU, 32'd7, 32'd0, 10);
        check32("divu0 hi kept", hi, 32'hFFFF_FFFF);
        check32("divu0 lo kept", lo, 32'hFFFF_FFFD);
        run_multi("divovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10);
        check32("divovf hi", hi, 32'h0000_0000);
        check32("divovf lo", lo, 32'h8000_0000);

        // msub: {0,10} - 12 wraps modulo 2^64
        drive(MD_MTHI, 1'b1, 32'd0, 32'd0);
        step();
        drive(MD_MTLO, 1'b1, 32'd10, 32'd0);
        step();
        idle_e();
        check32("preload hi", hi, 32'd0);
        check32("preload lo", lo, 32'd10);
        run_multi("msub", MD_MSUB, 32'd3, 32'd4, 5);
        check32("msub hi", hi, 32'hFFFF_FFFF);
        check32("msub lo", lo, 32'hFFFF_FFFE);
        drive(MD_MFLO, 1'b1, 32'd0, 32'd0);
        #1;
        check32("msub mflo", md_out, 32'hFFFF_FFFE);
        step();
        idle_e();

        // stall rule with a muldiv waiting in D
        d_muldiv = 1'b1;
        run_multi("stall mult", MD_MULT, 32'd5, 32'd7, 5);
        check32("stall released", 32'(stall_req), 32'd0);
        step();
        d_muldiv = 1'b0;
        drive(MD_MFLO, 1'b1, 32'd0, 32'd0);
        #1;
        check32("dependent mflo", md_out, 32'd35);
        step();
        idle_e();
        run_multi("nostall mult", MD_MULT, 32'd2, 32'd3, 5);
        check32("nostall lo", lo, 32'd6);

        // asynchronous reset in the middle of a divide
        drive(MD_DIV, 1'b1, 32'd100, 32'd7);
        step();
        idle_e();
        step();
        step();
        step();
        check32("mid-div busy", 32'(busy), 32'd1);
        d_muldiv = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        check32("async busy", 32'(busy), 32'd0);
        check32("async stall", 32'(stall_req), 32'd0);
        check32("async hi", hi, 32'd0);
        check32("async lo", lo, 32'd0);
        #1;
        reset    = 1'b0;
        d_muldiv = 1'b0;
        run_multi("post-reset mult", MD_MULT, 32'd6, 32'd7, 5);
        check32("post-reset hi", hi, 32'd0);
        check32("post-reset lo", lo, 32'd42);
        for (int i = 0; i < 10; i++) step();
        check32("no stale commit hi", hi, 32'd0);
        check32("no stale commit lo", lo, 32'd42);

        // mthi/mfhi, invalid E slot, no-op type
        drive(MD_MTHI, 1'b1, 32'h1234_5678, 32'd0);
        step();
        drive(MD_MFHI, 1'b1, 32'd0, 32'd0);
        #1;
        check32("mfhi md_out", md_out, 32'h1234_5678);
        check32("mthi hi", hi, 32'h1234_5678);
        step();
        drive(MD_MTLO, 1'b0, 32'h0000_AAAA, 32'd0);
        step();
        idle_e();
        check32("invalid mtlo lo", lo, 32'd42);
        drive(MD_MFHI, 1'b0, 32'd0, 32'd0);
        #1;
        check32("invalid mfhi md_out", md_out, 32'd0);
        drive(4'd12, 1'b1, 32'd9, 32'd9);
        #1;
        check32("noop start", 32'(start), 32'd0);
        step();
        idle_e();
        check32("noop busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
